bit_index_encoder: RTL and testbench
====================================

# bit_index_encoder

Sequential encoder that converts a WIDTH-bit set of flags into a stream of SELECTOR-bit indices, one per cycle, lowest set bit first. It is the inverse of the datapath's index-to-one-hot decoder: a flag vector is loaded with a valid/ready handshake, then each set bit is emitted as a binary index and cleared. It sits between any flag-producing logic (pending-interrupt bits, register-list masks) and consumers that take a single register or line number.

## Interface
Parameters:
- WIDTH, 32, flag vector width; must equal 2**SELECTOR
- SELECTOR, 5, index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous abort; discards pending bits
- load_valid  in  1  load_vec is valid
- load_ready  out  1  block can accept a load (IDLE only)
- load_vec  in  WIDTH  flag vector to encode
- idx_valid  out  1  idx is valid
- idx_ready  in  1  consumer accepts idx this cycle
- idx  out  SELECTOR  index of lowest pending set bit
- idx_last  out  1  idx is the final pending bit
- remaining  out  SELECTOR+1  popcount of pending bits (0..WIDTH)
- zero_load  out  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- Internal state: pend register (WIDTH bits), FSM {IDLE, EMIT}.
- IDLE: load_ready=1, idx_valid=0. On load_valid & load_ready:
  - load_vec != 0 -> pend <= load_vec, go EMIT.
  - load_vec == 0 -> pend stays 0, stay IDLE, zero_load=1 next cycle for exactly one cycle.
- EMIT: load_ready=0 (load_valid ignored), idx_valid=1.
  - idx = position of lowest set bit of pend (bit 0 highest priority).
  - idx_last = 1 iff pend has exactly one bit set.
  - On idx_valid & idx_ready: clear bit idx in pend; if idx_last -> IDLE, else stay EMIT.
  - idx_ready=0: pend, idx, idx_last held stable (no change while valid and not accepted).
- remaining = popcount(pend) in all states; 0 in IDLE.
- flush (sync, priority over every handshake): pend <= 0, FSM <= IDLE, no zero_load pulse. A transfer coinciding with flush is not counted as accepted by the block; an IDLE load coinciding with flush is discarded.
- reset (async): pend=0, FSM=IDLE, effective immediately, including mid-EMIT.
- idx, idx_last are 0 whenever idx_valid=0.

## Timing
- Reset values: load_ready=1, idx_valid=0, idx=0, idx_last=0, remaining=0, zero_load=0.
- Load accepted at edge N -> idx_valid=1 with first index after edge N (cycle N+1); no combinational path load_vec -> idx.
- Throughput: one index per cycle with idx_ready held high; vector with K set bits drains in K cycles.
- Final transfer at edge M -> load_ready=1 in cycle M+1; next load accepted at edge M+1 earliest (one IDLE cycle between vectors).
- zero_load high in cycle N+1 only after all-zero load at edge N; load_ready stays 1 throughout.
- idx, idx_last, remaining are registered-state decodes: stable for the whole cycle, no dependency on idx_ready.
- Full vector (all ones): remaining=WIDTH (6'd32) in first EMIT cycle; no overflow.

## Test plan
- Reset then load 32'h0000_0001, idx_ready=1 -> one cycle idx=0, idx_last=1, remaining=1; next cycle idx_valid=0, load_ready=1.
- Load 32'h8000_0005, idx_ready=1 -> idx 0,2,31 on consecutive cycles, remaining 3,2,1, idx_last only on 31.
- Load 32'h0000_0110, idx_ready low 3 cycles -> idx=4 held stable, remaining=2; raise idx_ready -> 4, then 8 with idx_last.
- Load 32'h0000_0000 -> zero_load pulse one cycle, idx_valid never rises, load_ready stays 1; load_valid during EMIT of another vector ignored.
- Load 32'hFFFF_FFFF -> 32 consecutive indices 0..31, remaining starts at 32, idx_last on 31, load_ready back the cycle after.
- Load 32'h0000_00F0, flush after idx 4 accepted -> IDLE next cycle, remaining=0; repeat with async reset mid-EMIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bit_index_encoder_if.sv
// Handshake bundle for bit_index_encoder: the flag-vector load side and the index stream side.
interface bit_index_encoder_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SELECTOR = 5
);
  logic                flush;
  logic                load_valid;
  logic                load_ready;
  logic [WIDTH-1:0]    load_vec;
  logic                idx_valid;
  logic                idx_ready;
  logic [SELECTOR-1:0] idx;
  logic                idx_last;
  logic [SELECTOR:0]   remaining;
  logic                zero_load;

  modport master (
    output flush, load_valid, load_vec, idx_ready,
    input  load_ready, idx_valid, idx, idx_last, remaining, zero_load
  );

  modport slave (
    input  flush, load_valid, load_vec, idx_ready,
    output load_ready, idx_valid, idx, idx_last, remaining, zero_load
  );
endinterface

// File: rtl/bit_index_encoder.sv
// Converts a loaded flag vector into a stream of binary indices, lowest set bit first,
// clearing each bit as its index is accepted.
module bit_index_encoder #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SELECTOR = 5
) (
  input logic               clk,
  input logic               reset,
  bit_index_encoder_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StEmit = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             zero_load_q, zero_load_d;

  logic [SELECTOR-1:0] lsb_idx;
  logic                lsb_found;
  logic [SELECTOR:0]   pop_cnt;
  logic                one_hot;

  // All outputs decode registered state only, so nothing depends on load_vec or idx_ready.
  always_comb begin
    lsb_idx   = '0;
    lsb_found = 1'b0;
    pop_cnt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i] && !lsb_found) begin
        lsb_idx   = SELECTOR'(i);
        lsb_found = 1'b1;
      end
      pop_cnt = pop_cnt + {{SELECTOR{1'b0}}, pend_q[i]};
    end
    one_hot = (pend_q != '0) && ((pend_q & (pend_q - 1'b1)) == '0);
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    zero_load_d = 1'b0;
    if (bus.flush) begin
      state_d = StIdle;
      pend_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.load_valid) begin
            if (bus.load_vec != '0) begin
              pend_d  = bus.load_vec;
              state_d = StEmit;
            end else begin
              zero_load_d = 1'b1;
            end
          end
        end
        StEmit: begin
          if (bus.idx_ready) begin
            // x & (x-1) drops exactly the lowest set bit, i.e. the one at lsb_idx.
            pend_d = pend_q & (pend_q - 1'b1);
            if (one_hot) begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          pend_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      zero_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      zero_load_q <= zero_load_d;
    end
  end

  always_comb begin
    bus.load_ready = (state_q == StIdle);
    bus.idx_valid  = (state_q == StEmit);
    bus.idx        = (state_q == StEmit) ? lsb_idx : '0;
    bus.idx_last   = (state_q == StEmit) ? one_hot : 1'b0;
    bus.remaining  = pop_cnt;
    bus.zero_load  = zero_load_q;
  end

endmodule

// File: tb/tb_bit_index_encoder.sv
// Directed self-checking bench for bit_index_encoder with hand-computed expectations.
module tb_bit_index_encoder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bit_index_encoder_if #(.WIDTH(32), .SELECTOR(5)) bus ();

  bit_index_encoder #(.WIDTH(32), .SELECTOR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic lr, input logic iv, input logic [31:0] ix,
                         input logic il, input logic [31:0] rem, input logic zl);
    chk({tag, ".load_ready"}, {31'b0, bus.load_ready}, {31'b0, lr});
    chk({tag, ".idx_valid"},  {31'b0, bus.idx_valid},  {31'b0, iv});
    chk({tag, ".idx"},        {27'b0, bus.idx},        ix);
    chk({tag, ".idx_last"},   {31'b0, bus.idx_last},   {31'b0, il});
    chk({tag, ".remaining"},  {26'b0, bus.remaining},  rem);
    chk({tag, ".zero_load"},  {31'b0, bus.zero_load},  {31'b0, zl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_vec   = '0;
    bus.idx_ready  = 1'b0;
    #12;
    chk_out("reset", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("post_reset", 1, 0, 0, 0, 0, 0);

    // Single bit
    bus.idx_ready  = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0001;
    tick();
    bus.load_valid = 1'b0;
    chk_out("one.emit", 0, 1, 0, 1, 1, 0);
    tick();
    chk_out("one.idle", 1, 0, 0, 0, 0, 0);

    // Sparse vector with bit 31
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h8000_0005;
    tick();
    bus.load_valid = 1'b0;
    chk_out("sparse.0", 0, 1, 0, 0, 3, 0);
    tick();
    chk_out("sparse.2", 0, 1, 2, 0, 2, 0);
    tick();
    chk_out("sparse.31", 0, 1, 31, 1, 1, 0);
    tick();
    chk_out("sparse.idle", 1, 0, 0, 0, 0, 0);

    // Back-pressure holds outputs
    bus.idx_ready  = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0110;
    tick();
    bus.load_valid = 1'b0;
    chk_out("stall.c1", 0, 1, 4, 0, 2, 0);
    tick();
    chk_out("stall.c2", 0, 1, 4, 0, 2, 0);
    tick();
    chk_out("stall.c3", 0, 1, 4, 0, 2, 0);
    bus.idx_ready = 1'b1;
    tick();
    chk_out("stall.8", 0, 1, 8, 1, 1, 0);
    tick();
    chk_out("stall.idle", 1, 0, 0, 0, 0, 0);

    // All-zero load
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0000;
    tick();
    bus.load_valid = 1'b0;
    chk_out("zero.pulse", 1, 0, 0, 0, 0, 1);
    tick();
    chk_out("zero.after", 1, 0, 0, 0, 0, 0);

    // load_valid during EMIT is ignored
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0003;
    tick();
    bus.load_vec   = 32'h0000_00F0;
    chk_out("ign.0", 0, 1, 0, 0, 2, 0);
    tick();
    chk_out("ign.1", 0, 1, 1, 1, 1, 0);
    tick();
    bus.load_valid = 1'b0;
    chk_out("ign.idle", 1, 0, 0, 0, 0, 0);
    tick();
    chk_out("ign.idle2", 1, 0, 0, 0, 0, 0);

    // Full vector
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'hFFFF_FFFF;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk_out($sformatf("full.%0d", i), 0, 1, i, (i == 31), 32 - i, 0);
      tick();
    end
    chk_out("full.idle", 1, 0, 0, 0, 0, 0);

    // Flush mid-EMIT
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_00F0;
    tick();
    bus.load_valid = 1'b0;
    chk_out("flush.4", 0, 1, 4, 0, 4, 0);
    tick();
    chk_out("flush.5", 0, 1, 5, 0, 3, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_out("flush.idle", 1, 0, 0, 0, 0, 0);

    // Load coinciding with flush is discarded
    bus.flush      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0005;
    tick();
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    chk_out("flush.load", 1, 0, 0, 0, 0, 0);

    // Zero load coinciding with flush gives no pulse
    bus.flush      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_0000;
    tick();
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    chk_out("flush.zero", 1, 0, 0, 0, 0, 0);

    // Async reset mid-EMIT
    bus.load_valid = 1'b1;
    bus.load_vec   = 32'h0000_00F0;
    tick();
    bus.load_valid = 1'b0;
    chk_out("arst.emit", 0, 1, 4, 0, 4, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("arst.now", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("arst.after", 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
